// File: rtl/fifo_burst_rd_ctrl_if.sv
// Bundle for the burst read sequencer: FIFO read side, upstream valid/ready
// side, and the enable and status lines.
interface fifo_burst_rd_ctrl_if #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned USEDW_W = 8
);
    logic               en;
    logic [USEDW_W-1:0] rdusedw;
    logic               rdempty;
    logic               rdreq;
    logic [DATA_W-1:0]  q;
    logic               up_ready;
    logic               data_valid;
    logic [DATA_W-1:0]  up_data;
    logic               up_sop;
    logic               up_eop;
    logic               burst_done;
    logic               err_underflow;

    // master: the sequencer; slave: the FIFO plus upstream consumer.
    modport master (
        input  en, rdusedw, rdempty, q, up_ready,
        output rdreq, data_valid, up_data, up_sop, up_eop, burst_done, err_underflow
    );

    modport slave (
        output en, rdusedw, rdempty, q, up_ready,
        input  rdreq, data_valid, up_data, up_sop, up_eop, burst_done, err_underflow
    );
endinterface

// File: rtl/fifo_burst_rd_ctrl.sv
// Burst read sequencer for the dual-clock FIFO (rdclk domain): reads exactly
// BURST_LEN words per burst into a 2-entry skid buffer and forwards them upstream.
module fifo_burst_rd_ctrl #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned BURST_LEN = 30,
    parameter int unsigned USEDW_W   = 8,
    parameter int unsigned GAP_CYC   = 4
) (
    input logic                  rdclk,
    input logic                  rst_n,
    fifo_burst_rd_ctrl_if.master bus
);

    localparam int unsigned CNT_W    = $clog2(BURST_LEN + 1);
    localparam int unsigned GAP_W    = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_READ,
        S_GAP
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  rd_cnt, rd_cnt_d;
    logic [CNT_W-1:0]  out_cnt, out_cnt_d;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
    logic [1:0]        occ, occ_d;
    logic              inflight;
    logic [DATA_W-1:0] slot0, slot0_d;
    logic [DATA_W-1:0] slot1, slot1_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic dv_c;
    logic xfer_c;
    logic rd_more_c;
    logic rdreq_c;
    logic last_xfer_c;

    // Read issue: a word may be requested only if the skid has room once the
    // in-flight word lands, or a word leaves this cycle.
    always_comb begin
        dv_c        = (occ != 2'd0);
        xfer_c      = dv_c && bus.up_ready;
        rd_more_c   = (rd_cnt < CNT_W'(BURST_LEN));
        rdreq_c     = (state == S_READ) && rd_more_c && !bus.rdempty &&
                      (((3'(occ) + 3'(inflight)) < 3'd2) || xfer_c);
        last_xfer_c = xfer_c && (out_cnt == CNT_W'(BURST_LEN - 1));
    end

    // Next-state and counters.
    always_comb begin
        state_d   = state;
        rd_cnt_d  = rd_cnt;
        out_cnt_d = out_cnt;
        gap_cnt_d = gap_cnt;
        done_d    = 1'b0;
        err_d     = err_q || ((state == S_READ) && rd_more_c && bus.rdempty);

        unique case (state)
            S_IDLE: begin
                if (bus.en) state_d = S_ARM;
            end
            S_ARM: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                end else if (bus.rdusedw >= USEDW_W'(BURST_LEN)) begin
                    state_d   = S_READ;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            S_READ: begin
                if (rdreq_c) rd_cnt_d = rd_cnt + CNT_W'(1);
                if (xfer_c && (out_cnt != CNT_W'(BURST_LEN))) out_cnt_d = out_cnt + CNT_W'(1);
                if (last_xfer_c) begin
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    if (GAP_CYC == 0) state_d = bus.en ? S_ARM : S_IDLE;
                    else              state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP_LAST)) state_d = bus.en ? S_ARM : S_IDLE;
                else                             gap_cnt_d = gap_cnt + GAP_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Skid buffer: slot0 is always the head; the in-flight word is pushed as it lands.
    always_comb begin
        occ_d   = occ;
        slot0_d = slot0;
        slot1_d = slot1;

        unique case ({inflight, xfer_c})
            2'b10: begin
                occ_d = occ + 2'd1;
                if (occ == 2'd0) slot0_d = bus.q;
                else             slot1_d = bus.q;
            end
            2'b01: begin
                occ_d   = occ - 2'd1;
                slot0_d = slot1;
            end
            2'b11: begin
                if (occ == 2'd1) begin
                    slot0_d = bus.q;
                end else begin
                    slot0_d = slot1;
                    slot1_d = bus.q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rd_cnt   <= '0;
            out_cnt  <= '0;
            gap_cnt  <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            slot0    <= '0;
            slot1    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            rd_cnt   <= rd_cnt_d;
            out_cnt  <= out_cnt_d;
            gap_cnt  <= gap_cnt_d;
            occ      <= occ_d;
            inflight <= rdreq_c;
            slot0    <= slot0_d;
            slot1    <= slot1_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Framing is decoded from registered state, so it holds while stalled.
    assign bus.rdreq         = rdreq_c;
    assign bus.data_valid    = dv_c;
    assign bus.up_data       = slot0;
    assign bus.up_sop        = dv_c && (out_cnt == '0);
    assign bus.up_eop        = dv_c && (out_cnt == CNT_W'(BURST_LEN - 1));
    assign bus.burst_done    = done_q;
    assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Scoreboard bench for fifo_burst_rd_ctrl: dut0 has GAP_CYC=4 and a FIFO model,
// dut1 has GAP_CYC=0 and is used for gap timing only.
module tb_fifo_burst_rd_ctrl;

    localparam int unsigned DW = 64;
    localparam int unsigned UW = 8;
    localparam int          BL = 30;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [UW-1:0] rdusedw = '0;
    logic          rdempty = 1'b0;
    logic          up_ready = 1'b1;
    logic [DW-1:0] q0 = '0;
    logic [31:0]   rd_seen = '0;

    always #5 clk = ~clk;

    fifo_burst_rd_ctrl_if #(.DATA_W(DW), .USEDW_W(UW)) bus0 ();
    fifo_burst_rd_ctrl_if #(.DATA_W(DW), .USEDW_W(UW)) bus1 ();

    assign bus0.en       = en;
    assign bus0.rdusedw  = rdusedw;
    assign bus0.rdempty  = rdempty;
    assign bus0.up_ready = up_ready;
    assign bus0.q        = q0;
    assign bus1.en       = en;
    assign bus1.rdusedw  = rdusedw;
    assign bus1.rdempty  = rdempty;
    assign bus1.up_ready = up_ready;
    assign bus1.q        = '0;

    fifo_burst_rd_ctrl #(.DATA_W(DW), .BURST_LEN(BL), .USEDW_W(UW), .GAP_CYC(4)) dut0 (
        .rdclk (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    fifo_burst_rd_ctrl #(.DATA_W(DW), .BURST_LEN(BL), .USEDW_W(UW), .GAP_CYC(0)) dut1 (
        .rdclk (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [5:0]  lg [0:255];
    logic [3:0]  bp_pat = 4'b1001;

    function automatic logic [63:0] word_of(input logic [31:0] n);
        return {n ^ 32'hC0DE_0000, n};
    endfunction

    // Non-show-ahead FIFO: q carries the requested word the cycle after rdreq.
    always @(posedge clk) begin
        if (bus0.rdreq) begin
            q0      <= word_of(rd_seen);
            rd_seen <= rd_seen + 32'd1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_burst(input logic [31:0] base);
        for (int i = 0; i < BL; i++)
            exp_q.push_back('{d: word_of(base + 32'(i)), sop: (i == 0), eop: (i == BL - 1)});
    endtask

    // Bit select into the per-cycle log: 0 rdreq0, 1 valid0, 2 done0, 3 rdreq1, 4 done1, 5 err0.
    function automatic int first_at(input int s, input int from);
        for (int i = from; i < 256; i++) if (lg[i][s]) return i;
        return -1;
    endfunction

    function automatic int cnt(input int s, input int from, input int to);
        int c = 0;
        for (int i = from; i < to; i++) if (lg[i][s]) c++;
        return c;
    endfunction

    // Entered at posedge+1; index 0 is the current cycle.
    task automatic cycles(input int n, input bit bp, input int en_off, input int emp_from);
        for (int i = 0; i < 256; i++) lg[i] = '0;
        for (int i = 0; i < n; i++) begin
            if (bp) up_ready = bp_pat[i % 4];
            if (i == en_off) en = 1'b0;
            rdempty = (emp_from >= 0) && (i >= emp_from) && (i < emp_from + 3);
            @(negedge clk);
            lg[i] = {bus0.err_underflow, bus1.burst_done, bus1.rdreq,
                     bus0.burst_done, bus0.data_valid, bus0.rdreq};
            @(posedge clk);
            #1;
        end
        up_ready = 1'b1;
        rdempty  = 1'b0;
    endtask

    task automatic settle(input string tag);
        en = 1'b0;
        cycles(40, 1'b0, -1, -1);
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_rdreq"}, 64'(bus0.rdreq), 64'd0);
        check({tag, "_valid"}, 64'(bus0.data_valid), 64'd0);
        check({tag, "_data"},  bus0.up_data, 64'd0);
        check({tag, "_sop"},   64'(bus0.up_sop), 64'd0);
        check({tag, "_eop"},   64'(bus0.up_eop), 64'd0);
        check({tag, "_done"},  64'(bus0.burst_done), 64'd0);
        check({tag, "_err"},   64'(bus0.err_underflow), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks stall hold.
    initial begin : monitor
        logic        prev_stall;
        logic [63:0] pd;
        logic        ps, pe;
        exp_t        e;
        prev_stall = 1'b0;
        pd = '0;
        ps = 1'b0;
        pe = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_data", bus0.up_data, pd);
                    check("stall_flags", 64'({bus0.data_valid, bus0.up_sop, bus0.up_eop}),
                          64'({1'b1, ps, pe}));
                end
                if (bus0.data_valid && up_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h expected no transfer at %0t",
                                 bus0.up_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", bus0.up_data, e.d);
                        check("word_framing", 64'({bus0.up_sop, bus0.up_eop}), 64'({e.sop, e.eop}));
                    end
                end
                prev_stall = bus0.data_valid && !up_ready;
                pd = bus0.up_data;
                ps = bus0.up_sop;
                pe = bus0.up_eop;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset values
        repeat (2) @(posedge clk);
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-rate burst; en drops mid-burst, burst still completes, then idle
        push_burst(rd_seen);
        en = 1'b1;
        rdusedw = 8'd30;
        cycles(60, 1'b0, 20, -1);
        check("t1_first_rdreq", 64'(first_at(0, 0)), 64'd2);
        check("t1_rdreq_run",   64'(cnt(0, 2, 32)), 64'd30);
        check("t1_rdreq_total", 64'(cnt(0, 0, 60)), 64'd30);
        check("t1_first_valid", 64'(first_at(1, 0)), 64'd4);
        check("t1_valid_run",   64'(cnt(1, 4, 34)), 64'd30);
        check("t1_done_idx",    64'(first_at(2, 0)), 64'd34);
        check("t1_done_cnt",    64'(cnt(2, 0, 60)), 64'd1);
        check("t1_no_err",      64'(cnt(5, 0, 60)), 64'd0);
        settle("t1");

        // Threshold: 29 never starts, 30 starts the next cycle
        en = 1'b1;
        rdusedw = 8'd29;
        cycles(20, 1'b0, -1, -1);
        check("t2_below_thr", 64'(cnt(0, 0, 20)), 64'd0);
        push_burst(rd_seen);
        rdusedw = 8'd30;
        cycles(60, 1'b0, 20, -1);
        check("t2_first_rdreq", 64'(first_at(0, 0)), 64'd1);
        check("t2_rdreq_total", 64'(cnt(0, 0, 60)), 64'd30);
        check("t2_done_cnt",    64'(cnt(2, 0, 60)), 64'd1);
        settle("t2");

        // Backpressure 1,0,0,1
        push_burst(rd_seen);
        en = 1'b1;
        rdusedw = 8'd30;
        cycles(150, 1'b1, 20, -1);
        check("t3_first_rdreq", 64'(first_at(0, 0)), 64'd2);
        check("t3_rdreq_total", 64'(cnt(0, 0, 150)), 64'd30);
        check("t3_done_cnt",    64'(cnt(2, 0, 150)), 64'd1);
        settle("t3");

        // Back-to-back bursts: 4 idle cycles (GAP_CYC=4), none with GAP_CYC=0
        push_burst(rd_seen);
        push_burst(rd_seen + 32'd30);
        en = 1'b1;
        rdusedw = 8'd60;
        cycles(110, 1'b0, 72, -1);
        check("t5_done_idx",      64'(first_at(2, 0)), 64'd34);
        check("t5_next_rdreq",    64'(first_at(0, 35)), 64'd39);
        check("t5_rdreq_run2",    64'(cnt(0, 39, 69)), 64'd30);
        check("t5_rdreq_total",   64'(cnt(0, 0, 110)), 64'd60);
        check("t5_done_cnt",      64'(cnt(2, 0, 110)), 64'd2);
        check("t5_gap0_done_idx", 64'(first_at(4, 0)), 64'd34);
        check("t5_gap0_next_req", 64'(first_at(3, 35)), 64'd35);
        settle("t5");

        // Underflow: rdempty for 3 cycles after word 10 is requested
        push_burst(rd_seen);
        en = 1'b1;
        rdusedw = 8'd30;
        cycles(60, 1'b0, 20, 13);
        check("t4_req_before",  64'(cnt(0, 2, 13)), 64'd11);
        check("t4_req_blocked", 64'(cnt(0, 13, 16)), 64'd0);
        check("t4_req_resume",  64'(first_at(0, 16)), 64'd16);
        check("t4_req_total",   64'(cnt(0, 0, 60)), 64'd30);
        check("t4_err_first",   64'(first_at(5, 0)), 64'd14);
        check("t4_err_sticky",  64'(cnt(5, 14, 60)), 64'd46);
        check("t4_done_cnt",    64'(cnt(2, 0, 60)), 64'd1);
        settle("t4");

        // Async reset mid-burst: outputs clear at once, outstanding words dropped
        push_burst(rd_seen);
        en = 1'b1;
        rdusedw = 8'd30;
        cycles(15, 1'b0, -1, -1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("t7_midrst");
        exp_q.delete();
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycles(10, 1'b0, -1, -1);
        check("t7_idle_after", 64'(cnt(0, 0, 10)), 64'd0);

        // Recovery burst after reset
        push_burst(rd_seen);
        en = 1'b1;
        cycles(60, 1'b0, 20, -1);
        check("t8_first_rdreq", 64'(first_at(0, 0)), 64'd2);
        check("t8_done_cnt",    64'(cnt(2, 0, 60)), 64'd1);
        settle("t8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
